// File: rtl/ext_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ext_mem_pkg
//  Brief    : Shared types and helpers for the external-memory block engine:
//             FSM state encoding, block-offset width helper, stats layout.
//  Revision : 1.0 - initial release
// ============================================================================
package ext_mem_pkg;

    // Engine control states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_DRAIN = 3'd2,
        ST_WR_BURST = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Statistics vector layout: {read_words, write_words, wait_cycles}
    localparam int STATS_CNT_W    = 32;
    localparam int STATS_W        = 3 * STATS_CNT_W;
    localparam int STATS_WAIT_LSB = 0;
    localparam int STATS_WR_LSB   = STATS_CNT_W;
    localparam int STATS_RD_LSB   = 2 * STATS_CNT_W;

    // Number of word-offset bits inside one block (log2 of a power of two)
    function automatic int block_off_w(input int words);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < words) w = i + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ext_mem_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ext_mem_rd_pipe
//  Brief    : Tracks reads in flight on a fixed-latency RAM port with a
//             valid-bit shift register and counts the returned words.
//             A clear flushes everything in flight so late data is dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module ext_mem_rd_pipe #(
    parameter int RD_LATENCY = 2,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_start,
    input  logic             i_issue,
    output logic             o_ret,
    output logic [CNT_W-1:0] o_ret_cnt
);

    logic [RD_LATENCY-1:0] r_vld;
    logic [CNT_W-1:0]      r_ret_cnt;

    // A return is suppressed in the cycle the transaction is being aborted
    assign o_ret     = r_vld[RD_LATENCY-1] & ~i_clear;
    assign o_ret_cnt = r_ret_cnt;

    // Shift issue markers toward the return slot; flushed on abort
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_vld <= '0;
        end else begin
            r_vld <= (r_vld << 1) | RD_LATENCY'(i_issue);
        end
    end

    // Count returned words for the current transaction
    always_ff @(posedge clk) begin
        if (rst || i_clear || i_start) begin
            r_ret_cnt <= '0;
        end else if (o_ret) begin
            r_ret_cnt <= r_ret_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ext_mem_block_engine.sv
`default_nettype none
// ============================================================================
//  Module   : ext_mem_block_engine
//  Brief    : Converts single-word and block requests from the system's
//             external memory port into pipelined accesses on a fixed-latency
//             synchronous word RAM port, absorbing backend stalls.
//             Optional statistics output enabled by macro EXT_MEM_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module ext_mem_block_engine
    import ext_mem_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int BLOCK_WORDS = 16,
    parameter int RD_LATENCY  = 2
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              mem_req_i,
    input  logic              mem_reqBlock_i,
    input  logic              mem_clear_i,
    input  logic              mem_rw_i,
    input  logic [ADDR_W-1:0] mem_add_i,
    input  logic [31:0]       mem_data_i,
    output logic [31:0]       mem_data_o,
    output logic              mem_valid_o,
    output logic              mem_ready_o,
    output logic              mem_done_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
`ifdef EXT_MEM_STATS_EN
    output logic [STATS_W-1:0] stats_o,
`endif
    input  logic              ram_wait_i
);

    localparam int                c_OFF_W     = block_off_w(BLOCK_WORDS);
    localparam int                c_CNT_W     = c_OFF_W + 1;
    localparam logic [ADDR_W-1:0] c_OFF_MASK  = ADDR_W'(BLOCK_WORDS - 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_blk;
    logic [ADDR_W-1:0]   r_base;
    logic [c_CNT_W-1:0]  r_issue_cnt;

    logic                w_accept;
    logic                w_issue_rd;
    logic                w_issue_wr;
    logic                w_issue_last;
    logic [c_CNT_W-1:0]  w_n;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_ret;
    logic [c_CNT_W-1:0]  w_ret_cnt;

    assign w_accept     = (r_state == ST_IDLE) & mem_req_i & ~mem_clear_i;
    assign w_n          = r_blk ? c_CNT_W'(BLOCK_WORDS) : c_CNT_W'(1);
    assign w_issue_last = (r_issue_cnt == (w_n - 1'b1));
    // Block bases are aligned, so adding the offset never crosses a block
    assign w_addr       = r_base + ADDR_W'(r_issue_cnt[c_OFF_W-1:0]);

    ext_mem_rd_pipe #(
        .RD_LATENCY (RD_LATENCY),
        .CNT_W      (c_CNT_W)
    ) u_rd_pipe (
        .clk       (clock_i),
        .rst       (reset_i),
        .i_clear   (mem_clear_i),
        .i_start   (w_accept),
        .i_issue   (w_issue_rd),
        .o_ret     (w_ret),
        .o_ret_cnt (w_ret_cnt)
    );

    // State register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch and issue counter
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_blk       <= 1'b0;
            r_base      <= '0;
            r_issue_cnt <= '0;
        end else if (w_accept) begin
            r_blk       <= mem_reqBlock_i;
            r_base      <= mem_reqBlock_i ? (mem_add_i & ~c_OFF_MASK) : mem_add_i;
            r_issue_cnt <= '0;
        end else if (mem_clear_i) begin
            r_issue_cnt <= '0;
        end else if (w_issue_rd || w_issue_wr) begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
        end
    end

    // Next-state decode and all port outputs; abort overrides everything
    always_comb begin
        w_next      = r_state;
        w_issue_rd  = 1'b0;
        w_issue_wr  = 1'b0;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        mem_ready_o = 1'b0;
        mem_done_o  = 1'b0;
        mem_valid_o = w_ret;
        mem_data_o  = w_ret ? ram_rdata_i : 32'h0;

        case (r_state)
            ST_IDLE: begin
                mem_ready_o = 1'b1;
                if (w_accept) begin
                    w_next = mem_rw_i ? ST_WR_BURST : ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                if (!ram_wait_i) begin
                    w_issue_rd = 1'b1;
                    ram_en_o   = 1'b1;
                    ram_addr_o = w_addr;
                    if (w_issue_last) w_next = ST_RD_DRAIN;
                end
            end
            ST_RD_DRAIN: begin
                if (w_ret_cnt == w_n) w_next = ST_DONE;
            end
            ST_WR_BURST: begin
                if (!ram_wait_i) begin
                    w_issue_wr  = 1'b1;
                    ram_en_o    = 1'b1;
                    ram_we_o    = 1'b1;
                    ram_addr_o  = w_addr;
                    ram_wdata_o = mem_data_i;
                    mem_valid_o = 1'b1;
                    if (w_issue_last) w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                mem_done_o = 1'b1;
                w_next     = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase

        if (mem_clear_i) begin
            w_next      = ST_IDLE;
            w_issue_rd  = 1'b0;
            w_issue_wr  = 1'b0;
            ram_en_o    = 1'b0;
            ram_we_o    = 1'b0;
            ram_addr_o  = '0;
            ram_wdata_o = '0;
            mem_valid_o = 1'b0;
            mem_data_o  = 32'h0;
            mem_done_o  = 1'b0;
        end
    end

`ifdef EXT_MEM_STATS_EN
    logic [STATS_CNT_W-1:0] r_rd_words;
    logic [STATS_CNT_W-1:0] r_wr_words;
    logic [STATS_CNT_W-1:0] r_wait_cycles;

    // Saturating activity counters; only a full reset clears them
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_rd_words    <= '0;
            r_wr_words    <= '0;
            r_wait_cycles <= '0;
        end else begin
            if (w_ret && (r_rd_words != '1)) begin
                r_rd_words <= r_rd_words + 1'b1;
            end
            if (w_issue_wr && (r_wr_words != '1)) begin
                r_wr_words <= r_wr_words + 1'b1;
            end
            if (ram_wait_i && ((r_state == ST_RD_ISSUE) || (r_state == ST_WR_BURST))
                && (r_wait_cycles != '1)) begin
                r_wait_cycles <= r_wait_cycles + 1'b1;
            end
        end
    end

    assign stats_o[STATS_RD_LSB   +: STATS_CNT_W] = r_rd_words;
    assign stats_o[STATS_WR_LSB   +: STATS_CNT_W] = r_wr_words;
    assign stats_o[STATS_WAIT_LSB +: STATS_CNT_W] = r_wait_cycles;
`endif

endmodule
`default_nettype wire

// File: doc/ext_mem_block_engine.md
Name: ext_mem_block_engine

Overview:
- Memory-side stage directly downstream of the internal system's external memory port.
- Consumes its single-word and block requests (req/reqBlock/clear/rw/add/data) and drives back data/done/ready/valid.
- Translates each request into pipelined accesses on a fixed-latency synchronous word RAM port (BRAM or SDRAM front-end).
- Decouples the cache-fill burst protocol from backend stalls.

Parameters:
- ADDR_W, 24, word-address width; matches the system's BW_WORD_ADDR.
- BLOCK_WORDS, 16, words per block transfer; power of two, 2..64.
- RD_LATENCY, 2, backend cycles from read issue to ram_rdata_i valid; range 1..8.

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- mem_req_i  in  1  request strobe; sampled only while mem_ready_o=1.
- mem_reqBlock_i  in  1  1=block transfer of BLOCK_WORDS words, 0=single word.
- mem_clear_i  in  1  abort: flush current transaction.
- mem_rw_i  in  1  1=write, 0=read.
- mem_add_i  in  ADDR_W  word address.
- mem_data_i  in  32  write data.
- mem_data_o  out  32  read data.
- mem_valid_o  out  1  read: mem_data_o valid; write: current mem_data_i word consumed.
- mem_ready_o  out  1  idle, able to accept a request.
- mem_done_o  out  1  one-cycle pulse at transaction completion.
- ram_en_o  out  1  backend access strobe.
- ram_we_o  out  1  backend write enable.
- ram_addr_o  out  ADDR_W  backend word address.
- ram_wdata_o  out  32  backend write data.
- ram_rdata_i  in  32  backend read data, RD_LATENCY cycles after the read issue.
- ram_wait_i  in  1  backend stall; no issue in a cycle where it is high.

Behaviour:
- Reset values: all outputs 0 except mem_ready_o=1; state IDLE; counters and read-latency pipeline cleared.
- Reset and mem_clear_i each have top priority in any state: state goes to IDLE next cycle, no done pulse, in-flight read returns discarded.
- Request latch: in IDLE, a request is accepted when mem_req_i=1 and mem_ready_o=1.
  - Latches rw, block flag and base address. Base = mem_add_i with its low log2(BLOCK_WORDS) bits zeroed if block, else mem_add_i unchanged.
  - mem_ready_o drops the cycle after acceptance.
- Word count: N = BLOCK_WORDS if block, else 1. Issue counter and return counter are each log2(BLOCK_WORDS)+1 bits.
- State machine:
  - IDLE: accept request -> RD_ISSUE (rw=0) or WR_BURST (rw=1).
  - RD_ISSUE: each cycle with ram_wait_i=0, issue read at base+issue_cnt (ram_en_o=1, ram_we_o=0), issue_cnt++. After N issues -> RD_DRAIN.
  - RD_DRAIN: wait until return_cnt==N -> DONE.
  - Read returns: a valid-bit shift register of depth RD_LATENCY tracks reads. Each return drives mem_data_o=ram_rdata_i and mem_valid_o=1 for one cycle, return_cnt++. Returns also arrive during RD_ISSUE.
  - WR_BURST: each cycle with ram_wait_i=0, write mem_data_i to base+issue_cnt (ram_en_o=1, ram_we_o=1, ram_wdata_o=mem_data_i) and pulse mem_valid_o=1. The requester presents the next word the following cycle. After N writes -> DONE.
  - DONE: mem_done_o=1 for one cycle -> IDLE with mem_ready_o=1 next cycle.
- Addresses never wrap across a block boundary. Single-word addressing at all-ones wraps modulo 2^ADDR_W.
- ram_wait_i stalls issue only; reads already in flight still return.
- Latency at ram_wait_i=0: single read gives done RD_LATENCY+3 cycles after acceptance. Block read gives BLOCK_WORDS+RD_LATENCY+2.
- mem_req_i while mem_ready_o=0 is ignored, not queued.

Optional Feature:
- Macro EXT_MEM_STATS_EN.
- When defined: adds output stats_o (96 bits) = {read_words[31:0], write_words[31:0], wait_cycles[31:0]}.
  - Saturating counters.
  - Cleared by reset_i only, not by mem_clear_i.
  - wait_cycles increments each cycle ram_wait_i=1 while state is RD_ISSUE or WR_BURST.
- When undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package ext_mem_pkg:
  - state enum (IDLE, RD_ISSUE, RD_DRAIN, WR_BURST, DONE)
  - BLOCK_OFF_W = log2(BLOCK_WORDS) helper function
  - stats field offsets
- One natural sub-module, ext_mem_rd_pipe: RD_LATENCY-deep valid shift register plus return counter, flushable by clear.

Test Plan:
- Single read, add=0x000123, RD_LATENCY=2, RAM preloaded 0xDEADBEEF -> ram_addr_o=0x000123 one cycle; one mem_valid_o with 0xDEADBEEF; mem_done_o exactly 5 cycles after accept.
- Block read, add=0x00004B, BLOCK_WORDS=16 -> addresses 0x40..0x4F in order; 16 valid pulses with matching data; done 20 cycles after accept.
- Block write of data 0x1000+k with ram_wait_i high on cycles 3-5 -> no ram_en_o during the wait; 16 writes total, each word written once at 0x80+k; done after final write.
- mem_clear_i asserted after 7 read returns -> IDLE and mem_ready_o=1 next cycle; no mem_done_o; remaining in-flight returns produce no mem_valid_o.
- mem_req_i held high through a transaction -> only one transaction accepted; second accepted only after mem_ready_o reasserts.
- With EXT_MEM_STATS_EN: block read, block write, single write with 3 wait cycles -> stats_o = {32'd16, 32'd17, 32'd3}.
